therm2bin_pipe: RTL and testbench
=================================

Name: therm2bin_pipe

Overview:
- Pipelined code-to-binary encoder for the sub-ADC comparator outputs of the pipeline ADC.
- Accepts either a one-hot code or a thermometer code, selected per sample by mode.
- Registers a binary result with valid and error flags.
- Keeps a saturating count of invalid codes, such as multiple-hot or thermometer bubbles, for debug/calibration readout.

Parameters:
WIDTH, 8, number of code bits (comparators); must be >= 2
OUT_W, $clog2(WIDTH+1), binary output width; covers 0..WIDTH
ERRCNT_W, 8, width of saturating error counter
HOLD_ON_ERR, 0, 1 = binary_o keeps last error-free value when a sample is invalid

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  code_i/mode_i valid this cycle
mode_i  input  1  0 = one-hot, 1 = thermometer
code_i  input  WIDTH  comparator code, bit 0 = lowest threshold
clr_i  input  1  synchronous clear of err_cnt_o
binary_o  output  OUT_W  encoded value
valid_o  output  1  binary_o/err_o valid
err_o  output  1  current output sample was an invalid code
err_cnt_o  output  ERRCNT_W  saturating count of invalid samples

Behaviour:
- Clocking and reset: single clock. Reset is asynchronous and active-low, on rst_ni. All state is in clk_i posedge flops with async clear.
- Reset values: binary_o=0, valid_o=0, err_o=0, err_cnt_o=0, all internal stage registers=0, last-good register=0.
- Stage 1 (input register): code/mode are captured only when valid_i=1. The stage-1 valid copies valid_i every cycle.
- Stage 2 (encode + output register): outputs update only when stage-1 valid=1.
- Latency: exactly 2 clk_i cycles from valid_i to valid_o. Throughput is 1 sample/cycle; no backpressure.
- Bubbles: valid_i=0 gives valid_o=0 two cycles later. binary_o and err_o hold their previous values.
- One-hot mode:
  - Exactly one bit set: result = its index, err=0.
  - Zero bits set: result=0, err=1.
  - More than one bit set: result = highest set index, err=1.
- Thermometer mode:
  - Result = number of ones in code (popcount, 0..WIDTH).
  - Valid code means all ones are contiguous from bit 0, including all-zero (=0) and all-one (=WIDTH); err=0.
  - Any 0 below a 1 (bubble) gives err=1; result is still the popcount (bubble-tolerant).
- HOLD_ON_ERR=1: when err=1, binary_o keeps the last error-free result and err_o=1. The last-good register updates only on valid, error-free samples.
- HOLD_ON_ERR=0: binary_o always shows the computed result.
- Error counter:
  - Increments by 1 on each output sample with valid=1 and err=1.
  - Saturates at 2^ERRCNT_W-1; never wraps.
  - clr_i=1 sets it to 0 next edge. clr_i has priority over a simultaneous increment, so the result is 0.
- Mode is sampled with the code in stage 1. A mode change between consecutive samples needs no idle cycle.
- Reset mid-stream: all in-flight samples are discarded, and valid_o=0 immediately (asynchronously) on rst_ni low. The first output after release comes 2 cycles after the first valid_i.
- Width rule: one-hot indices 0..WIDTH-1 and thermometer counts 0..WIDTH are zero-extended into OUT_W.

Test Plan:
- One-hot, WIDTH=8: valid_i=1, mode_i=0, code_i=8'h10 at cycle n -> binary_o=4, valid_o=1, err_o=0 at cycle n+2. Back-to-back 8'h01, 8'h80 -> 0 then 7 on consecutive cycles.
- Thermometer: code_i=8'h1F -> 5. 8'h00 -> 0, err_o=0. 8'hFF -> 8 (OUT_W=4), err_o=0.
- Invalid codes, HOLD_ON_ERR=0:
  - One-hot 8'h00 -> 0, err_o=1.
  - One-hot 8'h24 -> 5, err_o=1.
  - Thermometer 8'b00001011 -> 3, err_o=1.
  - err_cnt_o increments once per invalid sample.
- HOLD_ON_ERR=1: thermometer 8'h07 then bubble 8'h0B -> binary_o 3 then 3, with err_o 0 then 1. Next 8'h0F -> 4, err_o=0.
- Counter: ERRCNT_W=2, six consecutive invalid samples -> err_cnt_o 1,2,3,3,3,3. clr_i asserted in the same cycle as an invalid output -> err_cnt_o=0.
- Reset and bubbles:
  - valid_i pattern 1,0,1 -> valid_o pattern 1,0,1 delayed by 2, with binary_o held during the gap.
  - Assert rst_ni=0 while 2 samples are in flight -> all outputs 0 at once; no stale valid_o after release.

Source files
------------

// File: rtl/therm2bin_pipe.sv
// therm2bin_pipe: two-stage encoder that turns sub-ADC comparator outputs
// (one-hot or thermometer, chosen per sample) into a binary value. It flags
// malformed codes and keeps a saturating count of them for debug readout.

module therm2bin_pipe #(
    parameter int WIDTH       = 8,
    parameter int OUT_W       = $clog2(WIDTH + 1),
    parameter int ERRCNT_W    = 8,
    parameter bit HOLD_ON_ERR = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  logic                mode_i,
    input  logic [WIDTH-1:0]    code_i,
    input  logic                clr_i,
    output logic [OUT_W-1:0]    binary_o,
    output logic                valid_o,
    output logic                err_o,
    output logic [ERRCNT_W-1:0] err_cnt_o
);

    logic                r_s1Valid;
    logic                r_s1Mode;
    logic [WIDTH-1:0]    r_s1Code;

    logic [OUT_W-1:0]    r_binary;
    logic                r_valid;
    logic                r_err;
    logic [OUT_W-1:0]    r_lastGood;
    logic [ERRCNT_W-1:0] r_errCnt;

    logic [OUT_W-1:0]    w_popCount;
    logic [OUT_W-1:0]    w_highIdx;
    logic                w_thermOk;
    logic [OUT_W-1:0]    w_result;
    logic                w_err;

    // Stage 1: capture code and mode only for valid samples; valid always follows the input
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1Valid <= 1'b0;
            r_s1Mode  <= 1'b0;
            r_s1Code  <= '0;
        end else begin
            r_s1Valid <= valid_i;
            if (valid_i) begin
                r_s1Mode <= mode_i;
                r_s1Code <= code_i;
            end
        end
    end

    // Encoder: popcount, highest set index and thermometer contiguity check
    always_comb begin
        w_popCount = '0;
        w_highIdx  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popCount = w_popCount + OUT_W'(r_s1Code[i]);
            if (r_s1Code[i]) begin
                w_highIdx = OUT_W'(i);
            end
        end
        // Ones contiguous from bit 0 means adding 1 clears every set bit
        w_thermOk = ((r_s1Code + WIDTH'(1)) & r_s1Code) == '0;
        if (r_s1Mode) begin
            w_result = w_popCount;
            w_err    = !w_thermOk;
        end else begin
            w_result = w_highIdx;
            w_err    = (w_popCount != OUT_W'(1));
        end
    end

    // Stage 2: register result and flags; bubbles leave binary/err untouched
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_binary   <= '0;
            r_lastGood <= '0;
        end else begin
            r_valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_err <= w_err;
                if (!w_err) begin
                    r_lastGood <= w_result;
                end
                if (HOLD_ON_ERR && w_err) begin
                    r_binary <= r_lastGood;
                end else begin
                    r_binary <= w_result;
                end
            end
        end
    end

    // Error counter: counts invalid samples as they reach the output, saturates, clear wins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_errCnt <= '0;
        end else if (clr_i) begin
            r_errCnt <= '0;
        end else if (r_s1Valid && w_err && (r_errCnt != {ERRCNT_W{1'b1}})) begin
            r_errCnt <= r_errCnt + ERRCNT_W'(1);
        end
    end

    assign binary_o  = r_binary;
    assign valid_o   = r_valid;
    assign err_o     = r_err;
    assign err_cnt_o = r_errCnt;

endmodule

// File: tb/tb_therm2bin_pipe.sv
// Testbench for therm2bin_pipe: two instances share the stimulus, one with the
// default settings and one with hold-on-error and a 2-bit error counter.
// Expected responses are queued at issue time and popped by a monitor.

module tb_therm2bin_pipe;

    logic       clock = 1'b0;
    logic       resetN;
    logic       validIn;
    logic       modeIn;
    logic [7:0] codeIn;
    logic       clrIn;

    logic [3:0] binA;
    logic       validA;
    logic       errA;
    logic [7:0] cntA;
    logic [3:0] binB;
    logic       validB;
    logic       errB;
    logic [1:0] cntB;

    typedef struct {
        int bin;
        int err;
        int cntA;
        int binB;
        int cntB;
        int due;
    } exp_t;

    exp_t expQ[$];
    int   checks    = 0;
    int   fails     = 0;
    int   cycleCnt  = 0;
    int   mCntA     = 0;
    int   mCntB     = 0;
    int   mLastGood = 0;
    bit   prevValid = 1'b0;
    int   lastBinA  = 0;
    int   lastErrA  = 0;
    int   lastBinB  = 0;
    int   lastErrB  = 0;

    therm2bin_pipe #(
        .WIDTH(8), .ERRCNT_W(8), .HOLD_ON_ERR(1'b0)
    ) dutA (
        .clk_i(clock), .rst_ni(resetN), .valid_i(validIn), .mode_i(modeIn),
        .code_i(codeIn), .clr_i(clrIn), .binary_o(binA), .valid_o(validA),
        .err_o(errA), .err_cnt_o(cntA)
    );

    therm2bin_pipe #(
        .WIDTH(8), .ERRCNT_W(2), .HOLD_ON_ERR(1'b1)
    ) dutB (
        .clk_i(clock), .rst_ni(resetN), .valid_i(validIn), .mode_i(modeIn),
        .code_i(codeIn), .clr_i(clrIn), .binary_o(binB), .valid_o(validB),
        .err_o(errB), .err_cnt_o(cntB)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Edge counter used to time-stamp when each sample is due at the output
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // Drive one cycle of stimulus and queue the hand-computed response
    task automatic applyStimulus(input bit v, input bit m, input logic [7:0] c, input bit clr,
                                 input int expBin, input int expErr);
        exp_t e;
        int   idx;
        @(negedge clock);
        validIn = v;
        modeIn  = m;
        codeIn  = c;
        clrIn   = clr;
        if (clr) begin
            if (prevValid && expQ.size() > 0) begin
                idx = expQ.size() - 1;
                expQ[idx].cntA = 0;
                expQ[idx].cntB = 0;
            end
            mCntA = 0;
            mCntB = 0;
        end
        if (v) begin
            if (expErr != 0) begin
                if (mCntA < 255) mCntA++;
                if (mCntB < 3) mCntB++;
                e.binB = mLastGood;
            end else begin
                e.binB    = expBin;
                mLastGood = expBin;
            end
            e.bin  = expBin;
            e.err  = expErr;
            e.cntA = mCntA;
            e.cntB = mCntB;
            e.due  = cycleCnt + 2;
            expQ.push_back(e);
        end
        prevValid = v;
    endtask

    // Assert reset, confirm outputs clear immediately, discard in-flight expectations
    task automatic doReset();
        resetN  = 1'b0;
        validIn = 1'b0;
        clrIn   = 1'b0;
        #1;
        checkOutput("rstValidA", validA, 0);
        checkOutput("rstBinA", binA, 0);
        checkOutput("rstErrA", errA, 0);
        checkOutput("rstCntA", cntA, 0);
        checkOutput("rstValidB", validB, 0);
        checkOutput("rstBinB", binB, 0);
        checkOutput("rstCntB", cntB, 0);
        expQ.delete();
        mCntA = 0; mCntB = 0; mLastGood = 0; prevValid = 1'b0;
        lastBinA = 0; lastErrA = 0; lastBinB = 0; lastErrB = 0;
        repeat (3) @(negedge clock);
        #2 resetN = 1'b1;
    endtask

    // Monitor: pops when a sample is due, otherwise checks that outputs are held
    always @(negedge clock) begin
        bit   expV;
        exp_t e;
        if (resetN) begin
            expV = (expQ.size() > 0) && (expQ[0].due == cycleCnt);
            checkOutput("validA", validA, expV);
            checkOutput("validB", validB, expV);
            if (expV) begin
                e = expQ.pop_front();
                checkOutput("binA", binA, e.bin);
                checkOutput("errA", errA, e.err);
                checkOutput("cntA", cntA, e.cntA);
                checkOutput("binB", binB, e.binB);
                checkOutput("errB", errB, e.err);
                checkOutput("cntB", cntB, e.cntB);
                lastBinA = e.bin;  lastErrA = e.err;
                lastBinB = e.binB; lastErrB = e.err;
            end else begin
                checkOutput("holdBinA", binA, lastBinA);
                checkOutput("holdErrA", errA, lastErrA);
                checkOutput("holdBinB", binB, lastBinB);
                checkOutput("holdErrB", errB, lastErrB);
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        int budget;
        resetN  = 1'b1;
        validIn = 1'b0;
        modeIn  = 1'b0;
        codeIn  = 8'h00;
        clrIn   = 1'b0;
        #3;
        doReset();

        // One-hot, including back-to-back and a mode switch with no idle cycle
        applyStimulus(1, 0, 8'h10, 0, 4, 0);
        applyStimulus(1, 0, 8'h01, 0, 0, 0);
        applyStimulus(1, 0, 8'h80, 0, 7, 0);
        // Thermometer: mid, empty and full scale
        applyStimulus(1, 1, 8'h1F, 0, 5, 0);
        applyStimulus(1, 1, 8'h00, 0, 0, 0);
        applyStimulus(1, 1, 8'hFF, 0, 8, 0);
        // Invalid codes
        applyStimulus(1, 0, 8'h00, 0, 0, 1);
        applyStimulus(1, 0, 8'h24, 0, 5, 1);
        applyStimulus(1, 1, 8'h0B, 0, 3, 1);
        // Hold-on-error sequence
        applyStimulus(1, 1, 8'h07, 0, 3, 0);
        applyStimulus(1, 1, 8'h0B, 0, 3, 1);
        applyStimulus(1, 1, 8'h0F, 0, 4, 0);
        // Six invalid samples in a row to saturate the 2-bit counter
        applyStimulus(1, 0, 8'h00, 0, 0, 1);
        applyStimulus(1, 0, 8'h03, 0, 1, 1);
        applyStimulus(1, 1, 8'h05, 0, 2, 1);
        applyStimulus(1, 1, 8'h80, 0, 1, 1);
        applyStimulus(1, 0, 8'hFF, 0, 7, 1);
        applyStimulus(1, 1, 8'hFE, 0, 7, 1);
        // Clear coinciding with an invalid sample reaching the output
        applyStimulus(1, 0, 8'h42, 0, 6, 1);
        applyStimulus(1, 0, 8'h08, 1, 3, 0);
        // Bubble pattern 1,0,1
        applyStimulus(1, 1, 8'h03, 0, 2, 0);
        applyStimulus(0, 0, 8'hAA, 0, 0, 0);
        applyStimulus(1, 0, 8'h40, 0, 6, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);

        // Reset with two samples in flight
        applyStimulus(1, 0, 8'h04, 0, 2, 0);
        applyStimulus(1, 1, 8'h3F, 0, 6, 0);
        @(posedge clock);
        #1;
        doReset();
        repeat (3) applyStimulus(0, 0, 8'h00, 0, 0, 0);
        applyStimulus(1, 0, 8'h02, 0, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);

        // Drain with a bounded wait
        budget = 20;
        while (expQ.size() > 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        checkOutput("drainQueueEmpty", expQ.size(), 0);
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
